// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings (opcode/func values, field positions, bubble code)
// and the fetch FSM state type used by instr_fetch_unit.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BUBBLE = 6'b111111;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_FULL  = 2'd2,
    IFU_DRAIN = 2'd3
  } ifu_state_e;

  function automatic logic [5:0] opc_field(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [5:0] func_field(input logic [31:0] instr);
    return instr[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection for the fetch unit: sequential pc+4, or the BEQ target
// if_pc + 4 + (sext(imm16) << 2). All arithmetic wraps modulo 2^PC_WIDTH.
module ifu_pc_next
  import mips_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [PC_WIDTH-1:0] if_pc_i,
  input  logic [15:0]         br_offset_i,
  input  logic                redirect_i,
  input  logic                advance_i,
  output logic [PC_WIDTH-1:0] pc_next_o
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] if_pc_seq;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] target;

  always_comb begin
    pc_seq    = pc_i + PC_WIDTH'(4);
    if_pc_seq = if_pc_i + PC_WIDTH'(4);
    off_ext   = {{(PC_WIDTH-16){br_offset_i[IMM_MSB]}}, br_offset_i[IMM_MSB:IMM_LSB]} << 2;
    target    = (if_pc_seq + off_ext) & ALIGN_MASK;
    // A taken branch overrides any sequential advance in the same cycle.
    if (redirect_i) begin
      pc_next_o = target;
    end else if (advance_i) begin
      pc_next_o = pc_seq;
    end else begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over imem req/ack into a one-entry output
// register for decode. Optional stall counter port enabled by IFU_STALL_CNT_EN.
//
// state | meaning
// IDLE  | out of reset, first fetch starts next cycle
// FETCH | request presented whenever the output register is free
// FULL  | output register held, decode not ready, no request
// DRAIN | wrong-path request still in flight, its data is dropped
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                id_ready,
  input  logic                br_taken,
  input  logic [15:0]         br_offset,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [5:0]          id_opcode,
  output logic [5:0]          id_func
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_AL = RESET_PC & ~PC_WIDTH'(3);

  ifu_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;

  logic free;
  logic redirect;
  logic req;
  logic fetch_done;

  always_comb begin
    free     = !if_valid_q || id_ready;
    redirect = if_valid_q && id_ready && br_taken;

    // Gating the request on "free" keeps it stable until ack: once issued without
    // ack the output register is empty and stays empty until this very ack.
    case (state_q)
      IFU_FETCH: req = free;
      IFU_DRAIN: req = 1'b1;
      default:   req = 1'b0;
    endcase

    fetch_done = (state_q == IFU_FETCH) && req && imem_ack && !redirect;

    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;

    if (if_valid_q && id_ready) begin
      if_valid_d = 1'b0;
    end
    if (fetch_done) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
    end

    case (state_q)
      IFU_IDLE: state_d = IFU_FETCH;
      IFU_FETCH: begin
        if (redirect) begin
          if (!imem_ack) begin
            state_d      = IFU_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (!free) begin
          state_d = IFU_FULL;
        end
      end
      IFU_FULL:  if (id_ready) state_d = IFU_FETCH;
      IFU_DRAIN: if (imem_ack) state_d = IFU_FETCH;
      default:   state_d = IFU_IDLE;
    endcase
  end

  ifu_pc_next #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next (
    .pc_i       (pc_q),
    .if_pc_i    (if_pc_q),
    .br_offset_i(br_offset),
    .redirect_i (redirect),
    .advance_i  (fetch_done),
    .pc_next_o  (pc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC_AL;
      drain_addr_q <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((req && !imem_ack) || (if_valid_q && !id_ready)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // DRAIN keeps presenting the abandoned address; pc_q already holds the target.
  assign imem_req  = req;
  assign imem_addr = (state_q == IFU_DRAIN) ? drain_addr_q : pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign id_opcode = if_valid_q ? opc_field(if_instr_q) : OPC_BUBBLE;
  assign id_func   = if_valid_q ? func_field(if_instr_q) : OPC_BUBBLE;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming fetch, decode stall, taken BEQ with
// and without a pending request, PC wrap from a high reset PC, and async reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        imem_req, imem_ack, id_ready, br_taken, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
  logic [15:0] br_offset;
  logic [5:0]  id_opcode, id_func;

  logic        imem_req_b, imem_ack_b, id_ready_b, br_taken_b, if_valid_b;
  logic [31:0] imem_addr_b, imem_rdata_b, if_instr_b, if_pc_b;
  logic [15:0] br_offset_b;
  logic [5:0]  id_opcode_b, id_func_b;

`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_b;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  int wait_nxt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .br_taken(br_taken), .br_offset(br_offset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_opcode(id_opcode), .id_func(id_func)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
    .id_ready(id_ready_b), .br_taken(br_taken_b), .br_offset(br_offset_b),
    .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b),
    .id_opcode(id_opcode_b), .id_func(id_func_b)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt_b)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C08_0004;
      32'h0000_0004: return 32'h1000_0002;
      32'h0000_0010: return 32'h1000_FFFC;
      default:       return {6'b000000, a[21:2], 6'b100000};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs after the edge, memory answers, return at the negedge.
  task automatic drive(input logic rdy, input logic bt, input logic [15:0] off);
    @(posedge clk);
    #1;
    wait_cnt  = wait_nxt;
    id_ready  = rdy;
    br_taken  = bt;
    br_offset = off;
    #1;
    imem_ack     = imem_req && (wait_cnt >= mem_lat);
    imem_rdata   = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    wait_nxt     = (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    imem_ack_b   = imem_req_b;
    imem_rdata_b = mem_word(imem_addr_b);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0; br_taken = 1'b0; br_offset = '0;
    imem_ack_b = 1'b0; imem_rdata_b = '0; id_ready_b = 1'b1; br_taken_b = 1'b0; br_offset_b = '0;
    repeat (2) @(negedge clk);

    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_opc", id_opcode, 6'b111111);
    chk("rst_func", id_func, 6'b111111);
`ifdef IFU_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    chk("idle_req", imem_req, 1'b0);

    drive(1'b1, 1'b0, 16'h0);                         // c1
    chk("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", if_valid, 1'b0);
    chk("wrap_c1_addr", imem_addr_b, 32'hFFFF_FFFC);

    drive(1'b1, 1'b0, 16'h0);                         // c2
    chk("c2_valid", if_valid, 1'b1);
    chk("c2_instr", if_instr, 32'h8C08_0004);
    chk("c2_pc", if_pc, 32'h0);
    chk("c2_opc", id_opcode, 6'b100011);
    chk("c2_func", id_func, 6'b000100);
    chk("c2_addr", imem_addr, 32'h4);
    chk("wrap_c2_addr", imem_addr_b, 32'h0);
    chk("wrap_c2_pc", if_pc_b, 32'hFFFF_FFFC);

    drive(1'b1, 1'b0, 16'h0);                         // c3
    chk("c3_pc", if_pc, 32'h4);
    chk("c3_addr", imem_addr, 32'h8);
    chk("c3_opc", id_opcode, 6'b000100);
    chk("wrap_c3_pc", if_pc_b, 32'h0);

    drive(1'b0, 1'b0, 16'h0);                         // c4 decode stalls
    chk("c4_req", imem_req, 1'b0);
    chk("c4_pc", if_pc, 32'h8);
    chk("c4_instr", if_instr, 32'h0000_00A0);
    chk("c4_func", id_func, 6'b100000);

    drive(1'b0, 1'b1, 16'hFFFC);                      // c5 br_taken without id_ready
    chk("c5_req", imem_req, 1'b0);
    chk("c5_instr", if_instr, 32'h0000_00A0);

    drive(1'b0, 1'b1, 16'hFFFC);                      // c6
    chk("c6_req", imem_req, 1'b0);
    chk("c6_valid", if_valid, 1'b1);

    drive(1'b1, 1'b0, 16'h0);                         // c7 consumed from FULL
    chk("c7_req", imem_req, 1'b0);
    chk("c7_pc", if_pc, 32'h8);
`ifdef IFU_STALL_CNT_EN
    chk("c7_stall", stall_cnt, 32'd3);
`endif

    drive(1'b1, 1'b0, 16'h0);                         // c8
    chk("c8_req", imem_req, 1'b1);
    chk("c8_addr", imem_addr, 32'hC);
    chk("c8_valid", if_valid, 1'b0);

    drive(1'b1, 1'b0, 16'h0);                         // c9
    chk("c9_pc", if_pc, 32'hC);
    chk("c9_instr", if_instr, 32'h0000_00E0);
    chk("c9_addr", imem_addr, 32'h10);

    drive(1'b1, 1'b1, 16'hFFFC);                      // c10 BEQ taken, ack same cycle
    chk("c10_pc", if_pc, 32'h10);
    chk("c10_opc", id_opcode, 6'b000100);
    chk("c10_addr", imem_addr, 32'h14);

    drive(1'b1, 1'b0, 16'h0);                         // c11 redirected
    chk("c11_addr", imem_addr, 32'h4);
    chk("c11_valid", if_valid, 1'b0);
    chk("c11_opc", id_opcode, 6'b111111);

    mem_lat = 3;
    drive(1'b1, 1'b1, 16'h0002);                      // c12 BEQ taken, no ack
    chk("c12_pc", if_pc, 32'h4);
    chk("c12_instr", if_instr, 32'h1000_0002);
    chk("c12_addr", imem_addr, 32'h8);

    drive(1'b1, 1'b0, 16'h0);                         // c13 DRAIN
    chk("c13_req", imem_req, 1'b1);
    chk("c13_addr", imem_addr, 32'h8);
    chk("c13_valid", if_valid, 1'b0);

    drive(1'b1, 1'b0, 16'h0);                         // c14
    drive(1'b1, 1'b0, 16'h0);                         // c15 stale ack
    chk("c15_addr", imem_addr, 32'h8);
    chk("c15_ack", imem_ack, 1'b1);

    drive(1'b1, 1'b0, 16'h0);                         // c16
    chk("c16_addr", imem_addr, 32'h10);
    chk("c16_valid", if_valid, 1'b0);

    repeat (3) drive(1'b1, 1'b0, 16'h0);              // c17..c19
    chk("c19_valid", if_valid, 1'b0);
    drive(1'b1, 1'b0, 16'h0);                         // c20
    chk("c20_valid", if_valid, 1'b1);
    chk("c20_pc", if_pc, 32'h10);
    chk("c20_instr", if_instr, 32'h1000_FFFC);
    chk("c20_req", imem_req, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_req_wrap", imem_req_b, 1'b0);
    chk("arst_valid", if_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
